eval_rr_sched: RTL and testbench



---
 rtl/eval_sched_pkg.sv | 19 +
 rtl/eval_rr_sched_if.sv | 28 ++
 rtl/eval_gate_unit.sv | 27 ++
 rtl/eval_rr_sched.sv | 160 ++++++++++++++++
 tb/tb_eval_rr_sched.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eval_sched_pkg.sv
// Shared types for the round-robin evaluation scheduler: FSM states, the
// operation encoding and the settle-counter width.
package eval_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_BUF = 1'b0,
    OP_AND = 1'b1
  } op_e;

  // Wide enough for SETTLE_CYCLES up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/eval_rr_sched_if.sv
// Requester-side bus of the evaluation scheduler: per-requester request,
// operation and operand slices in, per-requester grant/done plus the shared
// result and busy flag out.
interface eval_rr_sched_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       op_sel;
  logic [N_REQ*WIDTH-1:0] opa;
  logic [N_REQ*WIDTH-1:0] opb;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic [WIDTH-1:0]       result;
  logic                   busy;

  // Requesters drive operands and requests, observe grant/done/result.
  modport master (
    output req, op_sel, opa, opb,
    input  gnt, done, result, busy
  );

  // The scheduler consumes requests and returns grant/done/result.
  modport slave (
    input  req, op_sel, opa, opb,
    output gnt, done, result, busy
  );
endinterface

// File: rtl/eval_gate_unit.sv
// Structural evaluation unit shared by all requesters: per bit a buf and an
// and primitive, followed by an op mux selecting which one reaches the output.
module eval_gate_unit
  import eval_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [WIDTH-1:0] y_o
);

  wire [WIDTH-1:0] buf_w;
  wire [WIDTH-1:0] and_w;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      buf u_buf (buf_w[i], opa_i[i]);
      and u_and (and_w[i], opa_i[i], opb_i[i]);
    end
  endgenerate

  assign y_o = (op_i == OP_AND) ? and_w : buf_w;

endmodule

// File: rtl/eval_rr_sched.sv
// Round-robin scheduler sharing one eval_gate_unit among N_REQ requesters.
// A grant latches the winner's operands, waits SETTLE_CYCLES in EVAL, then
// registers the result and pulses that requester's done for one RESP cycle.
// Optional feature macro: EVAL_SCHED_STATS_EN adds a saturating 16-bit
// grant_count output incremented on every RESP cycle.
module eval_rr_sched
  import eval_sched_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
`ifdef EVAL_SCHED_STATS_EN
  output logic [15:0] grant_count,
`endif
  eval_rr_sched_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;

  op_e                op_q;
  logic [WIDTH-1:0]   opa_q;
  logic [WIDTH-1:0]   opb_q;
  logic               load_ops;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [WIDTH-1:0]   eval_y;

  // Winner search: first set request above ptr, otherwise first set at or below it.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!win_found && bus.req[j] && (j > int'(ptr_q))) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!win_found && bus.req[j] && (j <= int'(ptr_q))) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
  end

  // The eval unit only ever sees the latched operands.
  eval_gate_unit #(
    .WIDTH(WIDTH)
  ) u_eval (
    .op_i  (op_q),
    .opa_i (opa_q),
    .opb_i (opb_q),
    .y_o   (eval_y)
  );

  // Next-state and output decode for the IDLE -> EVAL -> RESP cycle.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    result_d = result_q;
    load_ops = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_found) begin
          state_d  = EVAL;
          idx_d    = win_idx;
          gnt_d    = N_REQ'(1) << win_idx;
          cnt_d    = CNT_W'(SETTLE_CYCLES - 1);
          load_ops = 1'b1;
        end
      end
      EVAL: begin
        if (cnt_q == '0) begin
          state_d  = RESP;
          result_d = eval_y;
          done_d   = N_REQ'(1) << idx_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = idx_q;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Control and result registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= IDX_W'(N_REQ - 1);
      idx_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Operand latches: loaded only on a grant, so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (load_ops) begin
      op_q  <= op_e'(bus.op_sel[win_idx]);
      opa_q <= bus.opa[win_idx*WIDTH +: WIDTH];
      opb_q <= bus.opb[win_idx*WIDTH +: WIDTH];
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.busy   = (state_q != IDLE);

`ifdef EVAL_SCHED_STATS_EN
  logic [15:0] grant_count_q;

  // Saturating count of completed services.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_count_q <= '0;
    end else if ((state_q == RESP) && (grant_count_q != 16'hFFFF)) begin
      grant_count_q <= grant_count_q + 16'd1;
    end
  end

  assign grant_count = grant_count_q;
`endif

endmodule

// File: tb/tb_eval_rr_sched.sv
// Directed testbench for eval_rr_sched (N_REQ=4, WIDTH=8, SETTLE_CYCLES=1).
module tb_eval_rr_sched;

  localparam int N = 4;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  eval_rr_sched_if #(.N_REQ(N), .WIDTH(W)) bus ();

`ifdef EVAL_SCHED_STATS_EN
  logic [15:0] grant_count;
`endif

  eval_rr_sched #(
    .N_REQ(N),
    .WIDTH(W),
    .SETTLE_CYCLES(1)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef EVAL_SCHED_STATS_EN
    .grant_count (grant_count),
`endif
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic sel, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op_sel[i]       = sel;
    bus.opa[i*W +: W]   = a;
    bus.opb[i*W +: W]   = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req    = '0;
    bus.op_sel = '0;
    bus.opa    = '0;
    bus.opb    = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = '0; bus.op_sel = '0; bus.opa = '0; bus.opb = '0;
    #3;
    checks++;
    if ({bus.gnt, bus.done, bus.result, bus.busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got gnt=%b done=%b result=%h busy=%b exp all 0",
               bus.gnt, bus.done, bus.result, bus.busy);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
      failures++;
      $display("FAIL reset_idle got busy=%b gnt=%b exp 0/0000", bus.busy, bus.gnt);
    end
  endtask

  task automatic test_and_op();
    set_ops(0, 1'b1, 8'hF0, 8'h3C);
    bus.req = 4'b0001;
    step();
    checks++;
    if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1 || bus.done !== 4'b0000) begin
      failures++;
      $display("FAIL and_grant got gnt=%b busy=%b done=%b exp 0001/1/0000", bus.gnt, bus.busy, bus.done);
    end
    step();
    checks++;
    if (bus.done !== 4'b0001 || bus.result !== 8'h30 || bus.busy !== 1'b1 || bus.gnt !== 4'b0001) begin
      failures++;
      $display("FAIL and_done got done=%b result=%h busy=%b gnt=%b exp 0001/30/1/0001",
               bus.done, bus.result, bus.busy, bus.gnt);
    end
    bus.req = 4'b0000;
    step();
    checks++;
    if (bus.done !== 4'b0000 || bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.result !== 8'h30) begin
      failures++;
      $display("FAIL and_idle got done=%b gnt=%b busy=%b result=%h exp 0000/0000/0/30",
               bus.done, bus.gnt, bus.busy, bus.result);
    end
  endtask

  task automatic test_rr_all();
    logic [3:0] exp_gnt [5];
    logic [7:0] exp_res [5];
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_res = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, 1'b0, 8'(i), 8'hFF);
    bus.req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      step();
      checks++;
      if (bus.gnt !== exp_gnt[s] || bus.done !== 4'b0000) begin
        failures++;
        $display("FAIL rr_grant[%0d] got gnt=%b done=%b exp %b/0000", s, bus.gnt, bus.done, exp_gnt[s]);
      end
      step();
      checks++;
      if (bus.done !== exp_gnt[s] || bus.result !== exp_res[s]) begin
        failures++;
        $display("FAIL rr_done[%0d] got done=%b result=%h exp %b/%h", s, bus.done, bus.result, exp_gnt[s], exp_res[s]);
      end
      if (s == 4) bus.req = 4'b0000;
      step();
      checks++;
      if (bus.done !== 4'b0000 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL rr_idle[%0d] got done=%b busy=%b exp 0000/0", s, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_late_req();
    do_reset();
    set_ops(0, 1'b0, 8'h10, 8'h00);
    set_ops(1, 1'b0, 8'h11, 8'h00);
    set_ops(2, 1'b0, 8'h12, 8'h00);
    bus.req = 4'b0101;
    step();
    checks++;
    if (bus.gnt !== 4'b0001) begin
      failures++;
      $display("FAIL late_first got gnt=%b exp 0001", bus.gnt);
    end
    step();
    bus.req = 4'b0100;
    step();
    step();
    checks++;
    if (bus.gnt !== 4'b0100) begin
      failures++;
      $display("FAIL late_second got gnt=%b exp 0100", bus.gnt);
    end
    bus.req = 4'b0110;
    step();
    checks++;
    if (bus.done !== 4'b0100 || bus.result !== 8'h12) begin
      failures++;
      $display("FAIL late_second_done got done=%b result=%h exp 0100/12", bus.done, bus.result);
    end
    bus.req = 4'b0010;
    step();
    step();
    checks++;
    if (bus.gnt !== 4'b0010) begin
      failures++;
      $display("FAIL late_third got gnt=%b exp 0010", bus.gnt);
    end
    step();
    checks++;
    if (bus.done !== 4'b0010 || bus.result !== 8'h11) begin
      failures++;
      $display("FAIL late_third_done got done=%b result=%h exp 0010/11", bus.done, bus.result);
    end
    bus.req = 4'b0000;
    step();
  endtask

  task automatic test_operand_freeze();
    do_reset();
    set_ops(0, 1'b0, 8'hAA, 8'h00);
    bus.req = 4'b0001;
    step();
    set_ops(0, 1'b0, 8'h55, 8'h00);
    bus.req = 4'b0000;
    step();
    checks++;
    if (bus.done !== 4'b0001 || bus.result !== 8'hAA) begin
      failures++;
      $display("FAIL freeze_done got done=%b result=%h exp 0001/aa", bus.done, bus.result);
    end
    step();
    step();
    checks++;
    if (bus.done !== 4'b0000 || bus.gnt !== 4'b0000 || bus.result !== 8'hAA) begin
      failures++;
      $display("FAIL freeze_after got done=%b gnt=%b result=%h exp 0000/0000/aa", bus.done, bus.gnt, bus.result);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_ops(2, 1'b1, 8'h3C, 8'h0F);
    bus.req = 4'b0100;
    step();
    checks++;
    if (bus.gnt !== 4'b0100 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre got gnt=%b busy=%b exp 0100/1", bus.gnt, bus.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.gnt, bus.done, bus.busy} !== '0) begin
      failures++;
      $display("FAIL arst_immediate got gnt=%b done=%b busy=%b exp 0", bus.gnt, bus.done, bus.busy);
    end
    step();
    checks++;
    if (bus.done !== 4'b0000 || bus.result !== 8'h00) begin
      failures++;
      $display("FAIL arst_nodone got done=%b result=%h exp 0000/00", bus.done, bus.result);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.gnt !== 4'b0100) begin
      failures++;
      $display("FAIL arst_regrant got gnt=%b exp 0100", bus.gnt);
    end
    step();
    checks++;
    if (bus.done !== 4'b0100 || bus.result !== 8'h0C) begin
      failures++;
      $display("FAIL arst_done got done=%b result=%h exp 0100/0c", bus.done, bus.result);
    end
    bus.req = 4'b0000;
    step();
    // ptr now points at requester 2; a reset must send it back to N_REQ-1.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.req = 4'b1100;
    step();
    checks++;
    if (bus.gnt !== 4'b0100) begin
      failures++;
      $display("FAIL arst_ptr got gnt=%b exp 0100", bus.gnt);
    end
    bus.req = 4'b0000;
    step();
    step();
  endtask

`ifdef EVAL_SCHED_STATS_EN
  task automatic test_stats();
    do_reset();
    set_ops(0, 1'b0, 8'h01, 8'h00);
    bus.req = 4'b0001;
    for (int s = 0; s < 5; s++) begin
      step();
      step();
      if (s == 4) bus.req = 4'b0000;
      step();
    end
    checks++;
    if (grant_count !== 16'd5) begin
      failures++;
      $display("FAIL stats_count got %0d exp 5", grant_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant_count !== 16'd0) begin
      failures++;
      $display("FAIL stats_reset got %0d exp 0", grant_count);
    end
    step();
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    test_reset();
    test_and_op();
    test_rr_all();
    test_late_req();
    test_operand_freeze();
    test_async_reset();
`ifdef EVAL_SCHED_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
